// File: rtl/shift_right_pipe_pkg.sv
// Shared definitions for the pipelined right shifter.
//   DEFAULT_WIDTH / DEFAULT_SHW : default operand width and shift-amount width
//   fill_mode_e                 : encoding of the vacated-bit fill mode
package shift_right_pipe_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SHW   = 4;

  typedef enum logic {
    FILL_LOGICAL = 1'b0,
    FILL_ARITH   = 1'b1
  } fill_mode_e;

endpackage

// File: rtl/shift_right_stage.sv
// One stage of the pipelined right shifter: conditionally shifts the incoming
// word right by 2^STAGE when amount bit STAGE is set, folds the discarded bits
// into the sticky flag and registers the result.
//   clk, rst            : clock, synchronous active-high reset
//   adv_i               : global advance enable; registers load only when set
//   valid_i / valid_o   : slot occupancy in / out
//   data_i / data_o     : data word in / registered shifted word out
//   amt_i / amt_o       : full shift amount, carried alongside the data
//   arith_i / arith_o   : fill mode (FILL_ARITH = sign fill)
//   sticky_i / sticky_o : OR of every bit discarded so far
module shift_right_stage
  import shift_right_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = DEFAULT_SHW,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic             arith_i,
  input  logic             sticky_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output logic             arith_o,
  output logic             sticky_o
);

  localparam int SH = 1 << STAGE;
  // Bits that fall off the bottom when shifting by SH.
  localparam logic [WIDTH-1:0] LOST_MASK =
    (SH >= WIDTH) ? {WIDTH{1'b1}} : WIDTH'((64'd1 << SH) - 64'd1);

  logic                 fill;
  logic [2*WIDTH-1:0]   ext;
  logic [2*WIDTH-1:0]   ext_sh;
  logic [WIDTH-1:0]     data_d;
  logic                 sticky_d;

  logic                 valid_q;
  logic [WIDTH-1:0]     data_q;
  logic [SHW-1:0]       amt_q;
  logic                 arith_q;
  logic                 sticky_q;

  // An arithmetic shift never changes the MSB, so the MSB seen at any stage
  // is still the original sign bit and can serve as the fill value.
  always_comb begin
    fill     = (arith_i == FILL_ARITH) && data_i[WIDTH-1];
    ext      = {{WIDTH{fill}}, data_i};
    ext_sh   = ext >> SH;
    data_d   = data_i;
    sticky_d = sticky_i;
    if (amt_i[STAGE]) begin
      data_d   = (SH >= WIDTH) ? {WIDTH{fill}} : ext_sh[WIDTH-1:0];
      sticky_d = sticky_i | (|(data_i & LOST_MASK));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      amt_q    <= '0;
      arith_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else if (adv_i) begin
      valid_q  <= valid_i;
      data_q   <= data_d;
      amt_q    <= amt_i;
      arith_q  <= arith_i;
      sticky_q <= sticky_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign amt_o    = amt_q;
  assign arith_o  = arith_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/shift_right_pipe.sv
// Pipelined right shifter with logical/arithmetic fill and a sticky flag.
// SHW stages, stage k shifting by 2^k when amount bit k is set (LSB first);
// latency SHW cycles, one result per cycle at full throughput.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid, in_ready            : input handshake
//   in_data, in_amt, in_arith     : operand, shift amount, fill mode
//   out_valid, out_ready          : output handshake
//   out_data, out_sticky, out_zero: result, OR of discarded bits, result==0
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid never depends on ready on the same port; once out_valid is high
// the output stays unchanged until out_ready accepts it. The whole pipeline
// moves in lock step on adv = !out_valid || out_ready, and in_ready = adv, so
// a stalled output stalls every stage and the input together (bubbles inside
// the pipe are not squeezed out).
module shift_right_pipe
  import shift_right_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = DEFAULT_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic             out_zero
);

  logic             adv;
  logic             valid_s  [SHW+1];
  logic [WIDTH-1:0] data_s   [SHW+1];
  logic [SHW-1:0]   amt_s    [SHW+1];
  logic             arith_s  [SHW+1];
  logic             sticky_s [SHW+1];
  logic             unused_tail;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 0 input; an idle input cycle with adv=1 enters as a bubble.
  assign valid_s[0]  = in_valid;
  assign data_s[0]   = in_data;
  assign amt_s[0]    = in_amt;
  assign arith_s[0]  = in_arith;
  assign sticky_s[0] = 1'b0;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_right_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .STAGE (k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv_i    (adv),
      .valid_i  (valid_s[k]),
      .data_i   (data_s[k]),
      .amt_i    (amt_s[k]),
      .arith_i  (arith_s[k]),
      .sticky_i (sticky_s[k]),
      .valid_o  (valid_s[k+1]),
      .data_o   (data_s[k+1]),
      .amt_o    (amt_s[k+1]),
      .arith_o  (arith_s[k+1]),
      .sticky_o (sticky_s[k+1])
    );
  end

  // Amount and mode are fully consumed by the last stage.
  assign unused_tail = ^{amt_s[SHW], arith_s[SHW]};

  assign out_valid  = valid_s[SHW];
  assign out_data   = data_s[SHW];
  assign out_sticky = sticky_s[SHW];
  assign out_zero   = ~|data_s[SHW];

endmodule

// File: tb/tb_shift_right_pipe.sv
module tb_shift_right_pipe;
  import shift_right_pipe_pkg::*;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] in_amt;
  logic         in_arith;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sticky;
  logic         out_zero;

  shift_right_pipe #(.WIDTH(W), .SHW(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_arith   (in_arith),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_zero   (out_zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];   // {sticky, data}
  int         acc_q[$];   // cycle of acceptance
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         chk_lat = 1'b0;
  int         stall_seen = 0;
  bit         done_rand = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: integer division by 2^amt, floor for negative values.
  function automatic logic [W:0] model(input logic [W-1:0] d, input int amt, input logic ar);
    longint p;
    longint v;
    longint q;
    logic   st;
    p  = longint'(1) << amt;
    v  = longint'(d);
    st = (v % p) != 0;
    if (ar && d[W-1]) v = v - (longint'(1) << W);
    if (v >= 0) q = v / p;
    else        q = -((-v + p - 1) / p);
    return {st, q[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the operand is accepted.
  task automatic send(input logic [W-1:0] d, input logic [S-1:0] a, input logic ar);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_arith = ar;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      exp_q.push_back(model(d, int'(a), ar));
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- output monitor ----------------
  logic         stall_prev = 1'b0;
  logic [W-1:0] held_data;
  logic         held_sticky;
  logic         held_zero;

  always @(negedge clk) begin
    logic [W:0] e;
    int         a;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid",  32'(out_valid),  32'd1);
        check_eq("hold_data",   32'(out_data),   32'(held_data));
        check_eq("hold_sticky", 32'(out_sticky), 32'(held_sticky));
        check_eq("hold_zero",   32'(out_zero),   32'(held_zero));
      end
      if (out_valid && !out_ready) begin
        stall_seen++;
        check_eq("in_ready_stall", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check_eq("out_data",   32'(out_data),   32'(e[W-1:0]));
          check_eq("out_sticky", 32'(out_sticky), 32'(e[W]));
          check_eq("out_zero",   32'(out_zero),   32'(e[W-1:0] == '0));
          if (chk_lat) check_eq("latency", 32'(cyc - a), 32'(S));
        end
      end
      stall_prev  = out_valid && !out_ready;
      held_data   = out_data;
      held_sticky = out_sticky;
      held_zero   = out_zero;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_arith  = FILL_LOGICAL;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_out_valid",  32'(out_valid),  32'd0);
    check_eq("rst_out_data",   32'(out_data),   32'd0);
    check_eq("rst_out_sticky", 32'(out_sticky), 32'd0);
    check_eq("rst_out_zero",   32'(out_zero),   32'd1);
    check_eq("rst_in_ready",   32'(in_ready),   32'd1);
    @(posedge clk); #1;

    // Directed corner cases, latency checked
    chk_lat = 1'b1;
    send(16'h8000, 4'd15, FILL_LOGICAL); drain();
    send(16'h8000, 4'd3,  FILL_ARITH);   drain();
    send(16'h8000, 4'd3,  FILL_LOGICAL); drain();
    send(16'h00FF, 4'd4,  FILL_LOGICAL); drain();
    send(16'h0001, 4'd1,  FILL_LOGICAL); drain();
    send(16'hABCD, 4'd0,  FILL_LOGICAL); drain();
    send(16'hABCD, 4'd0,  FILL_ARITH);   drain();
    send(16'h8000, 4'd15, FILL_ARITH);   drain();
    send(16'h7FFF, 4'd15, FILL_ARITH);   drain();

    // Five back-to-back operands with a 3-cycle output stall
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(W'($urandom_range(0, 16'hFFFF)), S'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check_eq("stall_observed", 32'(stall_seen > 0), 32'd1);

    // Reset with three operands in flight; in_valid held during reset
    send(16'h1234, 4'd2, FILL_LOGICAL);
    send(16'h8765, 4'd5, FILL_ARITH);
    send(16'hFFFF, 4'd0, FILL_LOGICAL);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h5555;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("post_rst_valid", 32'(out_valid), 32'd0);
      if (i == 0) check_eq("post_rst_data", 32'(out_data), 32'd0);
      @(posedge clk); #1;
    end

    // Randomised traffic with random gaps and random backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [W-1:0] d;
          case ($urandom_range(0, 3))
            0:       d = W'(16'h8000 | $urandom_range(0, 16'h7FFF));
            1:       d = W'($urandom_range(0, 15));
            default: d = W'($urandom_range(0, 16'hFFFF));
          endcase
          send(d, S'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Full throughput: continuous input, out_ready high, latency checked
    chk_lat = 1'b1;
    for (int i = 0; i < 20; i++)
      send(W'($urandom_range(0, 16'hFFFF)), S'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_right_pipe.md
SHIFT_RIGHT_PIPE -- requirements
Module: shift_right_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data width in bits.
REQ-002 SHALL have parameter SHW, default 4, meaning shift-amount width; maximum shift is 2^SHW-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input operand present.
REQ-006 SHALL have port in_ready  output  1  block accepts the operand this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  operand to shift right.
REQ-008 SHALL have port in_amt  input  SHW  right-shift amount.
REQ-009 SHALL have port in_arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill).
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_data  output  WIDTH  shifted result.
REQ-013 SHALL have port out_sticky  output  1  OR of all bits shifted out.
REQ-014 SHALL have port out_zero  output  1  out_data equals zero.

Function
REQ-015 SHALL implement a SHW-stage pipeline: stage k conditionally shifts right by 2^k, selected by amount bit k, LSB first.
REQ-016 SHALL register each stage: data, remaining amount bits, arith flag, sticky, valid.
REQ-017 SHALL fill vacated MSBs with in_data[WIDTH-1] when arith=1, otherwise with 0.
REQ-018 SHALL accumulate sticky per stage as the OR of the bits discarded at that stage.
REQ-019 SHALL present the result exactly SHW cycles after acceptance when out_ready is held high (latency 4 at default).
REQ-020 SHALL use a global advance enable adv = !out_valid || out_ready; all stages shift together only when adv=1.
REQ-021 SHALL drive in_ready = adv; an operand is accepted only on in_valid && in_ready.
REQ-022 SHALL insert a bubble (valid=0) at stage 0 when adv=1 and in_valid=0.
REQ-023 SHALL hold out_data, out_sticky, out_zero and out_valid stable while out_valid=1 && out_ready=0.
REQ-024 SHALL sustain one result per cycle with in_valid and out_ready continuously high.
REQ-025 SHALL pass the operand unchanged with sticky=0 when in_amt=0.
REQ-026 SHALL give all-ones for a negative operand and 0 for a non-negative one in arith mode with in_amt=2^SHW-1 and WIDTH=2^SHW.
REQ-027 SHALL preserve operand order; no result is dropped, duplicated or reordered under any out_ready pattern.
REQ-028 SHALL compute out_zero combinationally from the output-stage data register.
REQ-029 SHALL complete the shift within the pipeline; bubbles are not collapsed.

Reset
REQ-030 SHALL on rst=1 clear every stage valid bit, every data register and every sticky register to 0 on the next clk edge.
REQ-031 SHALL therefore reset out_valid=0, out_data=0, out_sticky=0 and out_zero=1.
REQ-032 SHALL discard all in-flight operands on reset mid-operation; none emerge afterwards.
REQ-033 SHALL ignore in_valid in a cycle where rst=1.

Structure
REQ-034 SHALL put the default WIDTH and SHW constants and the fill-mode encoding (LOGICAL=0, ARITH=1) in the shared shifter package.
REQ-035 SHALL instantiate one sub-module, shift_right_stage, SHW times, parameterised by stage index and WIDTH; it holds the registers and conditional shift of one stage.

Verification
REQ-036 SHALL cover: 0x8000, amt 15, logical -> 0x0001, sticky 0, out_zero 0, four cycles after acceptance.
REQ-037 SHALL cover: 0x8000, amt 3, arith -> 0xF000, sticky 0; and 0x8000, amt 3, logical -> 0x1000.
REQ-038 SHALL cover: 0x00FF, amt 4, logical -> 0x000F, sticky 1; and 0x0001, amt 1 -> 0x0000, sticky 1, out_zero 1.
REQ-039 SHALL cover: five back-to-back operands with out_ready low for 3 cycles -> in_ready deasserts, output held stable, all five results emerge in order with no loss.
REQ-040 SHALL cover: rst pulsed with three operands in flight -> out_valid 0 from the next cycle, no stale result appears in the following 8 cycles.
REQ-041 SHALL cover: 0xABCD, amt 0, either mode -> 0xABCD, sticky 0.
